// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: PC/imem request-response side plus the decode-facing head entry.
// slave is the queue itself, master is whatever drives it (PC logic, imem, decode).
interface fetch_queue_if;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  modport slave (
    input  pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, out_ready,
    output pc_en, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );

  modport master (
    output pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, out_ready,
    input  pc_en, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue: slots are allocated at request issue, filled by responses,
// and drained by decode; a flush squashes queued entries and drops in-flight responses.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t alloc_ptr, fill_ptr, read_ptr, drop_cnt;
  ptr_t allocated, pending, filled, drop_nxt;
  logic [DEPTH-1:0][31:0] slot_pc, slot_instr;
  logic req_fire, rsp_write, rsp_drop, deq;

  assign allocated = alloc_ptr - read_ptr;
  assign pending   = alloc_ptr - fill_ptr;
  assign filled    = fill_ptr - read_ptr;

  assign bus.imem_req_valid = !rst && !bus.flush && (drop_cnt == '0) && (allocated < PW'(DEPTH));
  assign bus.imem_req_addr  = bus.pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.pc_en          = req_fire || (bus.flush && !rst);

  assign rsp_write = bus.imem_rsp_valid && !bus.flush && (drop_cnt == '0) && (pending != '0);
  assign rsp_drop  = bus.imem_rsp_valid && !bus.flush && (drop_cnt != '0);

  // Head outputs come straight from registered state; out_ready only moves read_ptr.
  assign bus.out_valid = (filled != '0);
  assign bus.out_pc    = slot_pc[read_ptr[AW-1:0]];
  assign bus.out_instr = slot_instr[read_ptr[AW-1:0]];
  assign deq           = bus.out_valid && bus.out_ready;

  // drop_cnt is nonzero only while the pointers sit at zero, so the sum never exceeds DEPTH;
  // a response landing in the flush cycle retires one of the outstanding fetches.
  always_comb begin
    drop_nxt = drop_cnt + pending;
    if (bus.imem_rsp_valid && (drop_nxt != '0))
      drop_nxt = drop_nxt - ptr_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      read_ptr   <= '0;
      drop_cnt   <= '0;
      slot_pc    <= '0;
      slot_instr <= '0;
    end else if (bus.flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop_cnt  <= drop_nxt;
    end else begin
      if (req_fire) begin
        slot_pc[alloc_ptr[AW-1:0]] <= bus.pc;
        alloc_ptr                  <= alloc_ptr + ptr_t'(1);
      end
      if (rsp_write) begin
        slot_instr[fill_ptr[AW-1:0]] <= bus.imem_rsp_data;
        fill_ptr                     <= fill_ptr + ptr_t'(1);
      end
      if (rsp_drop)
        drop_cnt <= drop_cnt - ptr_t'(1);
      if (deq)
        read_ptr <= read_ptr + ptr_t'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: bench-side PC register and optional 1-cycle memory.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mem_auto = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  int   fire_cnt = 0;
  int   rsp_cnt = 0;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // One clock: sample before the edge, then update the PC register and memory model.
  task automatic tick();
    logic fire, pce, fl;
    logic [31:0] a;
    #1;
    fire = bus.imem_req_valid && bus.imem_req_ready;
    pce  = bus.pc_en;
    fl   = bus.flush;
    a    = bus.imem_req_addr;
    if (fire) fire_cnt++;
    if (bus.imem_rsp_valid) rsp_cnt++;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (fl) bus.pc = flush_pc;
      else if (pce) bus.pc = bus.pc + 32'd4;
    end
    if (mem_auto) begin
      bus.imem_rsp_valid = fire;
      bus.imem_rsp_data  = fire ? instr_of(a) : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_auto = 1'b0;
    bus.pc = 32'h0;
    bus.flush = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    fire_cnt = 0;
    rsp_cnt = 0;
  endtask

  task automatic test_reset();
    bus.pc = 32'h40; bus.flush = 1'b0; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b want 0", bus.pc_en); end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h/%h want 0/0", bus.out_pc, bus.out_instr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h40) begin errors++; $display("FAIL post_reset_addr: got %h want 00000040", bus.imem_req_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    mem_auto = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL stream_pc_en: got %b want 1", bus.pc_en); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_fill_gap: got %b want 0", bus.out_valid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== 32'(4*k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.out_pc, 32'(4*k)); end
      checks++; if (bus.out_instr !== instr_of(32'(4*k))) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.out_instr, instr_of(32'(4*k))); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %b want 1", k, bus.imem_req_valid); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_auto = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (fire_cnt != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", fire_cnt); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL bp_pc_en: got %b want 0", bus.pc_en); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== instr_of(32'h0))
      begin errors++; $display("FAIL bp_head: got %b %h %h want 1 00000000 %h", bus.out_valid, bus.out_pc, bus.out_instr, instr_of(32'h0)); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== instr_of(32'h0) || fire_cnt != 4)
      begin errors++; $display("FAIL bp_stable: got %h %h acc=%0d want 00000000 %h acc=4", bus.out_pc, bus.out_instr, fire_cnt, instr_of(32'h0)); end
  endtask

  task automatic test_flush_no_rsp();
    do_reset();
    bus.out_ready = 1'b0;
    tick(); tick();
    checks++; if (fire_cnt != 2) begin errors++; $display("FAIL fl_setup_acc: got %0d want 2", fire_cnt); end
    flush_pc = 32'h100;
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_cycle: pc_en=%b req=%b want 1 0", bus.pc_en, bus.imem_req_valid); end
    tick();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop2: req=%b out_valid=%b want 0 0", bus.imem_req_valid, bus.out_valid); end
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_0000;
    tick();
    bus.imem_rsp_data = 32'hDEAD_0004;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_drop1: req=%b want 0", bus.imem_req_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_req_addr !== 32'h100)
      begin errors++; $display("FAIL fl_resume: req=%b out_valid=%b addr=%h want 1 0 00000100", bus.imem_req_valid, bus.out_valid, bus.imem_req_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = instr_of(32'h100);
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== instr_of(32'h100))
      begin errors++; $display("FAIL fl_third_rsp: got %b %h %h want 1 00000100 %h", bus.out_valid, bus.out_pc, bus.out_instr, instr_of(32'h100)); end
  endtask

  task automatic test_flush_with_rsp();
    do_reset();
    bus.out_ready = 1'b0;
    tick(); tick();
    flush_pc = 32'h200;
    bus.flush = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBEEF_0000;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flr_cycle: pc_en=%b req=%b want 1 0", bus.pc_en, bus.imem_req_valid); end
    tick();
    bus.flush = 1'b0;
    bus.imem_rsp_data = 32'hBEEF_0004;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flr_drop1: req=%b want 0", bus.imem_req_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_req_addr !== 32'h200)
      begin errors++; $display("FAIL flr_resume: req=%b out_valid=%b addr=%h want 1 0 00000200", bus.imem_req_valid, bus.out_valid, bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    mem_auto = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 10; cyc++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (bus.imem_req_valid !== ((fire_cnt - n) < DEPTH)) begin errors++; $display("FAIL wrap_full[%0d]: req=%b alloc=%0d", cyc, bus.imem_req_valid, fire_cnt - n); end
      checks++; if (bus.out_valid !== ((rsp_cnt - n) > 0)) begin errors++; $display("FAIL wrap_empty[%0d]: out_valid=%b filled=%0d", cyc, bus.out_valid, rsp_cnt - n); end
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_pc !== 32'(4*n) || bus.out_instr !== instr_of(32'(4*n)))
          begin errors++; $display("FAIL wrap_data[%0d]: got %h %h want %h %h", n, bus.out_pc, bus.out_instr, 32'(4*n), instr_of(32'(4*n))); end
        n++;
      end
      tick();
    end
    checks++; if (n != 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", n); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_auto = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: out_valid=%b want 1", bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.pc_en !== 1'b0)
      begin errors++; $display("FAIL arst_mid: out_valid=%b req=%b pc_en=%b want 0 0 0", bus.out_valid, bus.imem_req_valid, bus.pc_en); end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_no_rsp();
    test_flush_with_rsp();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, entries in queue; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc  input  32  current fetch address from the PC register.
REQ-005 pc_en  output  1  advance the PC register this cycle.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_addr  output  32  fetch address; equals pc.
REQ-008 imem_req_ready  input  1  instruction memory accepts request.
REQ-009 imem_rsp_valid  input  1  instruction word returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 flush  input  1  redirect; discard all queued and in-flight fetches.
REQ-012 out_valid  output  1  decode-side entry valid.
REQ-013 out_pc  output  32  PC of head entry.
REQ-014 out_instr  output  32  instruction of head entry.
REQ-015 out_ready  input  1  decode accepts head entry.

Function
REQ-016 Circular buffer of DEPTH slots {pc, instr}, with three pointers: alloc (request issue), fill (response write), read (head); each pointer is log2(DEPTH) bits plus a wrap bit.
REQ-017 allocated = alloc - read; pending = alloc - fill; filled = fill - read; all modulo 2*DEPTH.
REQ-018 imem_req_valid = !rst && !flush && drop_cnt == 0 && allocated < DEPTH.
REQ-019 Request accepted when imem_req_valid && imem_req_ready: slot[alloc].pc <= pc, and alloc increments.
REQ-020 pc_en = request accepted || flush, combinational; no other cycle asserts pc_en.
REQ-021 Response with drop_cnt == 0 and pending > 0: slot[fill].instr <= imem_rsp_data, and fill increments.
REQ-022 Response with drop_cnt > 0: data discarded; drop_cnt decrements.
REQ-023 Response with pending == 0 and drop_cnt == 0: ignored; no state change.
REQ-024 out_valid = (filled > 0); out_pc and out_instr driven from slot[read]; all three are registered-state outputs with no combinational path from out_ready.
REQ-025 Handshake out_valid && out_ready: read increments; out_pc and out_instr stay stable while out_valid && !out_ready.
REQ-026 Throughput: 1 request, 1 response and 1 dequeue in the same cycle SHALL all complete; a full queue (allocated == DEPTH) with dequeue issues no request that cycle.
REQ-027 Latency: a response written at edge N is visible on out_valid/out_instr in cycle N+1.
REQ-028 Flush: next state has alloc = fill = read = 0 and drop_cnt = pending - (response this cycle ? 1 : 0), where pending is evaluated before the flush.
REQ-029 A response arriving in the flush cycle is discarded and is not counted in drop_cnt.
REQ-030 An out handshake in the flush cycle completes from decode's perspective; the queue is still fully cleared.
REQ-031 No request is issued in the flush cycle; requests resume in the first cycle with drop_cnt == 0.
REQ-032 drop_cnt width is log2(DEPTH)+1 bits and never underflows.
REQ-033 Pointer wrap: indices wrap from DEPTH-1 to 0 and the wrap bit toggles; full and empty are distinguished by the wrap bit.

Reset
REQ-034 While rst is high: pointers = 0, drop_cnt = 0, out_valid = 0, imem_req_valid = 0, pc_en = 0; out_pc and out_instr = 0.
REQ-035 Reset asserted mid-operation clears all state immediately; responses to pre-reset requests are the memory's responsibility to squash.
REQ-036 imem_req_valid SHALL be 1 in the first cycle after rst deasserts, provided flush = 0.

Verification
REQ-037 Streaming: ready always 1, 1-cycle memory, pc 0x0,0x4,0x8 -> out sequence (0x0,I0),(0x4,I1),(0x8,I2), one per cycle after 2-cycle fill.
REQ-038 Backpressure: out_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0 and pc_en = 0; head stays (0x0,I0) stable.
REQ-039 Flush with 2 pending and no same-cycle response -> drop_cnt = 2; next two responses discarded; third response appears at out with the post-flush pc.
REQ-040 Flush with 2 pending plus a same-cycle response -> drop_cnt = 1; pc_en = 1 in the flush cycle; imem_req_valid = 0 until drop_cnt = 0.
REQ-041 Wrap: 10 entries through DEPTH = 4 with random out_ready -> in-order delivery with no loss or duplication; full/empty correct across wrap.
REQ-042 Asynchronous rst pulse mid-burst (between clock edges) -> out_valid = 0 and imem_req_valid = 0 before the next edge.
